// File: rtl/itof_pkg.sv
// itof_pkg: shared types and constants for the integer-to-float pipeline.
//   fp32_t   : IEEE-754 single-precision layout {sign, exp, man}
//   FP_BIAS  : exponent bias
//   FP_EXP_W : exponent field width
//   FP_MAN_W : mantissa field width
//   INT_W    : integer operand width
package itof_pkg;

    localparam int unsigned FP_BIAS  = 127;
    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;
    localparam int unsigned INT_W    = 32;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/lzc32.sv
// lzc32: purely combinational 32-bit leading-zero counter.
// Five levels of binary search. Each level tests whether the upper half of the
// current window is all zero and keeps whichever half holds the leading one.
// Ports:
//   value [31:0] in  : operand
//   count [5:0]  out : number of leading zeros; 32 when value is zero
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    logic [4:0]  c;
    logic [15:0] w16;
    logic [7:0]  w8;
    logic [3:0]  w4;
    logic [1:0]  w2;

    always_comb begin
        c[4] = (value[31:16] == 16'h0);
        w16  = c[4] ? value[15:0] : value[31:16];
        c[3] = (w16[15:8] == 8'h0);
        w8   = c[3] ? w16[7:0] : w16[15:8];
        c[2] = (w8[7:4] == 4'h0);
        w4   = c[2] ? w8[3:0] : w8[7:4];
        c[1] = (w4[3:2] == 2'b00);
        w2   = c[1] ? w4[1:0] : w4[3:2];
        c[0] = ~w2[1];
        // The last window is empty only if every window was, i.e. value == 0.
        count = (w2 == 2'b00) ? 6'd32 : {1'b0, c};
    end

endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: three-stage 32-bit integer to IEEE-754 single-precision converter,
// round-to-nearest-even, valid/ready on both sides with per-stage backpressure
// so bubbles collapse.
//   S1: sign / magnitude   S2: normalise   S3: round and pack
// Parameters:
//   IN_SIGNED : 1 = in_int is two's complement, 0 = unsigned
// Optional feature (macro ITOF_INEXACT_EN): adds out_inexact, registered with
// out_float under the same valid/hold rules.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_ready is combinational from out_ready
//   in_int [31:0]       : integer operand
//   out_valid/out_ready : output handshake
//   out_float [31:0]    : {sign, exp[7:0], man[22:0]}
//   out_inexact         : result was rounded (ITOF_INEXACT_EN only)
module itof_pipe
    import itof_pkg::*;
#(
    parameter bit IN_SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float
`ifdef ITOF_INEXACT_EN
    ,
    output logic             out_inexact
`endif
);

    // Exponent of a value whose leading one sits at bit INT_W-1.
    localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_BIAS + INT_W - 1);

    logic v1_q, v2_q, v3_q;
    logic ld1, ld2, ld3;

    // A stage loads when empty or when its successor loads this cycle.
    assign ld3       = ~v3_q | out_ready;
    assign ld2       = ~v2_q | ld3;
    assign ld1       = ~v1_q | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3_q;

    // ---------------- S1: sign / magnitude ----------------
    logic             s1_sign_d, s1_zero_d;
    logic [INT_W-1:0] s1_mag_d;
    logic             s1_sign_q, s1_zero_q;
    logic [INT_W-1:0] s1_mag_q;

    always_comb begin
        s1_sign_d = IN_SIGNED & in_int[INT_W-1];
        // Modulo 2^32 negate: -2^31 maps to 32'h8000_0000, correct as unsigned.
        s1_mag_d  = s1_sign_d ? (~in_int + 32'd1) : in_int;
        s1_zero_d = (in_int == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mag_q  <= '0;
        end else if (ld1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_mag_q  <= s1_mag_d;
            end
        end
    end

    // ---------------- S2: normalise ----------------
    logic [5:0]          lz;
    logic [INT_W-1:0]    s2_norm_d;
    logic [FP_EXP_W-1:0] s2_exp_d;
    logic                s2_sign_q, s2_zero_q;
    logic [INT_W-1:0]    s2_norm_q;
    logic [FP_EXP_W-1:0] s2_exp_q;

    lzc32 u_lzc (
        .value (s1_mag_q),
        .count (lz)
    );

    always_comb begin
        s2_norm_d = s1_mag_q << lz;
        s2_exp_d  = EXP_TOP - {2'b00, lz};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q      <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
            s2_exp_q  <= '0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_norm_q <= s2_norm_d;
                s2_exp_q  <= s2_exp_d;
            end
        end
    end

    // ---------------- S3: round and pack ----------------
    logic        rnd_g, rnd_s, rnd_l, rnd_inc;
    logic [24:0] m25;
    fp32_t       res_d;
    fp32_t       out_q;

    always_comb begin
        rnd_g   = s2_norm_q[7];
        rnd_s   = |s2_norm_q[6:0];
        rnd_l   = s2_norm_q[8];
        rnd_inc = rnd_g & (rnd_s | rnd_l);
        m25     = {1'b0, s2_norm_q[31:8]} + {24'h0, rnd_inc};
        res_d   = '0;
        if (!s2_zero_q) begin
            res_d.sign = s2_sign_q;
            if (m25[24]) begin
                // Carry out of the mantissa: value is an exact power of two.
                res_d.exp = s2_exp_q + 8'd1;
                res_d.man = '0;
            end else begin
                res_d.exp = s2_exp_q;
                res_d.man = m25[22:0];
            end
        end
    end

`ifdef ITOF_INEXACT_EN
    logic inexact_q;
    assign out_inexact = inexact_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q      <= 1'b0;
            out_q     <= '0;
`ifdef ITOF_INEXACT_EN
            inexact_q <= 1'b0;
`endif
        end else if (ld3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                out_q     <= res_d;
`ifdef ITOF_INEXACT_EN
                inexact_q <= rnd_g | rnd_s;
`endif
            end
        end
    end

    assign out_float = out_q;

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed self-checking bench for itof_pipe.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A second instance covers IN_SIGNED = 0.
module tb_itof_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_int, out_float;
    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
    logic [31:0] u_in_int, u_out_float;
`ifdef ITOF_INEXACT_EN
    logic        out_inexact, u_out_inexact;
`endif

    int checks   = 0;
    int failures = 0;

    itof_pipe #(.IN_SIGNED(1'b1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float)
`ifdef ITOF_INEXACT_EN
        ,
        .out_inexact (out_inexact)
`endif
    );

    itof_pipe #(.IN_SIGNED(1'b0)) u_dut_uns (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (u_in_valid),
        .in_ready  (u_in_ready),
        .in_int    (u_in_int),
        .out_valid (u_out_valid),
        .out_ready (u_out_ready),
        .out_float (u_out_float)
`ifdef ITOF_INEXACT_EN
        ,
        .out_inexact (u_out_inexact)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_int = '0; out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_int = '0; u_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_float !== 32'h0) begin
            failures++; $display("FAIL reset_out_float got=%h exp=00000000", out_float);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_uns got valid=%b ready=%b exp valid=0 ready=1",
                     u_out_valid, u_in_ready);
        end
`ifdef ITOF_INEXACT_EN
        checks++;
        if (out_inexact !== 1'b0) begin
            failures++; $display("FAIL reset_inexact got=%b exp=0", out_inexact);
        end
`endif
    endtask

    task automatic test_basic();
        logic [31:0] vin [4];
        logic [31:0] vexp [4];
        logic        exp_v;
        vin[0] = 32'd0;         vexp[0] = 32'h0000_0000;
        vin[1] = 32'd1;         vexp[1] = 32'h3F80_0000;
        vin[2] = 32'hFFFF_FFFF; vexp[2] = 32'hBF80_0000;
        vin[3] = 32'd7;         vexp[3] = 32'h40E0_0000;
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            out_ready = 1'b1;
            in_valid  = (c < 4);
            if (c < 4) in_int = vin[c];
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL basic_in_ready c=%0d got=%b exp=1", c, in_ready);
            end
            exp_v = (c >= 3 && c < 7);
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL basic_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (out_float !== vexp[c-3]) begin
                    failures++;
                    $display("FAIL basic_float c=%0d got=%h exp=%h", c, out_float, vexp[c-3]);
                end
            end
        end
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_extremes();
        logic [31:0] vin [5];
        logic [31:0] vexp [5];
        logic        vinx [5];
        int          lat;
        vin[0] = 32'h8000_0000; vexp[0] = 32'hCF00_0000; vinx[0] = 1'b0;
        vin[1] = 32'h7FFF_FFFF; vexp[1] = 32'h4F00_0000; vinx[1] = 1'b1;
        vin[2] = 32'd16777217;  vexp[2] = 32'h4B80_0000; vinx[2] = 1'b1;
        vin[3] = 32'd16777219;  vexp[3] = 32'h4B80_0002; vinx[3] = 1'b1;
        vin[4] = 32'd16777216;  vexp[4] = 32'h4B80_0000; vinx[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_int    = vin[i];
            @(negedge clk);
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            lat = 1;
            while (!out_valid && lat < 8) begin
                next_cycle();
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != 3 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL ext_latency i=%0d got=%0d valid=%b exp=3", i, lat, out_valid);
            end
            checks++;
            if (out_float !== vexp[i]) begin
                failures++;
                $display("FAIL ext_float in=%h got=%h exp=%h", vin[i], out_float, vexp[i]);
            end
`ifdef ITOF_INEXACT_EN
            checks++;
            if (out_inexact !== vinx[i]) begin
                failures++;
                $display("FAIL ext_inexact in=%h got=%b exp=%b", vin[i], out_inexact, vinx[i]);
            end
`else
            if (vinx[i] === 1'bx) $display("note: unexpected X in inexact table");
`endif
            next_cycle();
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] vin [2];
        logic [31:0] vexp [2];
        logic        exp_v;
        vin[0] = 32'hFFFF_FFFF; vexp[0] = 32'h4F80_0000;
        vin[1] = 32'h8000_0000; vexp[1] = 32'h4F00_0000;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            u_out_ready = 1'b1;
            u_in_valid  = (c < 2);
            if (c < 2) u_in_int = vin[c];
            @(negedge clk);
            exp_v = (c == 3 || c == 4);
            checks++;
            if (u_out_valid !== exp_v) begin
                failures++;
                $display("FAIL uns_out_valid c=%0d got=%b exp=%b", c, u_out_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (u_out_float !== vexp[c-3]) begin
                    failures++;
                    $display("FAIL uns_float c=%0d got=%h exp=%h", c, u_out_float, vexp[c-3]);
                end
            end
        end
        next_cycle();
        u_in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] vin [6];
        logic [31:0] vexp [6];
        int          idx = 0;
        int          nout = 0;
        int          extra = 0;
        vin[0] = 32'd1; vexp[0] = 32'h3F80_0000;
        vin[1] = 32'd2; vexp[1] = 32'h4000_0000;
        vin[2] = 32'd3; vexp[2] = 32'h4040_0000;
        vin[3] = 32'd4; vexp[3] = 32'h4080_0000;
        vin[4] = 32'd5; vexp[4] = 32'h40A0_0000;
        vin[5] = 32'd6; vexp[5] = 32'h40C0_0000;
        for (int c = 0; c < 8; c++) begin
            out_ready = 1'b0;
            in_valid  = (idx < 6);
            if (idx < 6) in_int = vin[idx];
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_float !== vexp[0]) begin
                    failures++;
                    $display("FAIL bp_hold c=%0d got=%h exp=%h", c, out_float, vexp[0]);
                end
            end
            if (in_valid && in_ready) idx++;
            next_cycle();
        end
        checks++;
        if (idx != 3) begin
            failures++; $display("FAIL bp_accepted got=%0d exp=3", idx);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
        end
        for (int c = 0; c < 30 && nout < 6; c++) begin
            out_ready = 1'b1;
            in_valid  = (idx < 6);
            if (idx < 6) in_int = vin[idx];
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                checks++;
                if (out_float !== vexp[nout]) begin
                    failures++;
                    $display("FAIL bp_order n=%0d got=%h exp=%h", nout, out_float, vexp[nout]);
                end
                nout++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 6) begin
            failures++; $display("FAIL bp_count got=%0d exp=6", nout);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) extra++;
            next_cycle();
        end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL bp_duplicates got=%0d exp=0", extra);
        end
    endtask

    task automatic test_bubble();
        logic [31:0] vin [3];
        logic [31:0] vexp [3];
        int          idx = 0;
        int          occ = 0;
        int          nout = 0;
        vin[0] = 32'd3;         vexp[0] = 32'h4040_0000;
        vin[1] = 32'hFFFF_FFFE; vexp[1] = 32'hC000_0000;
        vin[2] = 32'd100;       vexp[2] = 32'h42C8_0000;
        for (int c = 0; c < 6; c++) begin
            out_ready = 1'b0;
            in_valid  = ((c % 2) == 0) && (idx < 3);
            if (idx < 3) in_int = vin[idx];
            @(negedge clk);
            checks++;
            if (in_ready !== (occ < 3)) begin
                failures++;
                $display("FAIL bubble_in_ready c=%0d got=%b exp=%b", c, in_ready, occ < 3);
            end
            checks++;
            if (out_valid !== (c >= 3)) begin
                failures++;
                $display("FAIL bubble_out_valid c=%0d got=%b exp=%b", c, out_valid, c >= 3);
            end
            if (out_valid) begin
                checks++;
                if (out_float !== vexp[0]) begin
                    failures++;
                    $display("FAIL bubble_hold c=%0d got=%h exp=%h", c, out_float, vexp[0]);
                end
            end
            if (in_valid && in_ready) begin
                occ++;
                idx++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10 && nout < 3; c++) begin
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_float !== vexp[nout]) begin
                    failures++;
                    $display("FAIL bubble_drain n=%0d got=%h exp=%h", nout, out_float, vexp[nout]);
                end
                nout++;
            end
            next_cycle();
        end
        checks++;
        if (nout != 3) begin
            failures++; $display("FAIL bubble_count got=%0d exp=3", nout);
        end
    endtask

    task automatic test_reset_mid();
        int nout = 0;
        int lat  = 0;
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_int    = 32'd5 + c;
            next_cycle();
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_int    = 32'd9;
        out_ready = 1'b1;
        next_cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_float !== 32'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state got valid=%b float=%h ready=%b exp 0/00000000/1",
                     out_valid, out_float, in_ready);
        end
        next_cycle();
        in_valid = 1'b1;
        in_int   = 32'd2;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (out_valid) begin
                nout++;
                lat = c;
                checks++;
                if (out_float !== 32'h4000_0000) begin
                    failures++;
                    $display("FAIL midreset_float got=%h exp=40000000", out_float);
                end
            end
            next_cycle();
        end
        checks++;
        if (nout != 1 || lat != 3) begin
            failures++;
            $display("FAIL midreset_outputs got count=%0d lat=%0d exp count=1 lat=3", nout, lat);
        end
    endtask

    initial begin
        test_reset();
        next_cycle();
        test_basic();
        test_extremes();
        test_unsigned();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
